// File: rtl/pick_best_uv.sv
// Chroma (U+V) RD mode decision: score = rate*lambda + 256*(disto+sd), keep the minimum.
// Latency: done rises 2 cycles after the last accepted in_valid (stage 1 product, stage 2 compare).
// Backpressure: none; in_valid may arrive every cycle, inputs outside COLLECT are dropped.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, lambda    begin a new decision (aborts any running one), latch lambda
//   in_valid         rate/disto/sd valid for the next mode in arrival order
//   rate, disto, sd  per-mode rate and distortion terms (unsigned 32 b)
//   busy             decision in progress
//   best_mode/score/rate  current winner; final when done pulses
//   done             one-cycle pulse at the end of a decision
module pick_best_uv #(
   parameter int NUM_MODES = 4,
   parameter int MODE_W    = 2,
   parameter int LAMBDA_W  = 16,
   parameter int SCORE_W   = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [LAMBDA_W-1:0] lambda,
   input  logic                in_valid,
   input  logic [31:0]         rate,
   input  logic [31:0]         disto,
   input  logic [31:0]         sd,
   output logic                busy,
   output logic [MODE_W-1:0]   best_mode,
   output logic [SCORE_W-1:0]  best_score,
   output logic [31:0]         best_rate,
   output logic                done
);

   localparam int PR_W = 32 + LAMBDA_W;
   localparam int PD_W = 41;
   localparam logic [MODE_W-1:0] LAST = MODE_W'(NUM_MODES - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

   state_t              state;
   logic [MODE_W-1:0]   cnt;
   logic [LAMBDA_W-1:0] lam_q;

   // stage 1 registers
   logic                s1_vld;
   logic [PR_W-1:0]     p_rate;
   logic [PD_W-1:0]     p_dist;
   logic [MODE_W-1:0]   s1_tag;
   logic [31:0]         s1_rate;

   logic                accept;
   logic [32:0]         dist_sum;
   logic [SCORE_W-1:0]  s2_score;

   // start takes priority, so an in_valid in the same cycle is dropped
   assign accept   = (state == COLLECT) && in_valid && !start;
   assign dist_sum = {1'b0, disto} + {1'b0, sd};
   assign s2_score = SCORE_W'(p_rate) + SCORE_W'(p_dist);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         lam_q      <= '0;
         s1_vld     <= 1'b0;
         p_rate     <= '0;
         p_dist     <= '0;
         s1_tag     <= '0;
         s1_rate    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         best_mode  <= '0;
         best_score <= '0;
         best_rate  <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            // abort: flush the pipeline so no stale entry can raise done
            state  <= COLLECT;
            busy   <= 1'b1;
            cnt    <= '0;
            s1_vld <= 1'b0;
            lam_q  <= lambda;
         end else begin
            s1_vld <= accept;
            if (accept) begin
               p_rate  <= PR_W'(rate) * PR_W'(lam_q);
               p_dist  <= {dist_sum, 8'd0};
               s1_tag  <= cnt;
               s1_rate <= rate;
               cnt     <= cnt + 1'b1;
               if (cnt == LAST) state <= DRAIN;
            end
            if (s1_vld) begin
               // strict less-than: a tie keeps the earlier (lower) mode
               if (s1_tag == '0 || s2_score < best_score) begin
                  best_mode  <= s1_tag;
                  best_score <= s2_score;
                  best_rate  <= s1_rate;
               end
               if (s1_tag == LAST) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_pick_best_uv.sv
module tb_pick_best_uv;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] lambda = '0;
   logic        in_valid = 1'b0;
   logic [31:0] rate = '0, disto = '0, sd = '0;
   logic        busy, done;
   logic [1:0]  best_mode;
   logic [63:0] best_score;
   logic [31:0] best_rate;

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;
   int d0;

   pick_best_uv #(.NUM_MODES(4), .MODE_W(2), .LAMBDA_W(16), .SCORE_W(64)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .lambda(lambda),
      .in_valid(in_valid), .rate(rate), .disto(disto), .sd(sd),
      .busy(busy), .best_mode(best_mode), .best_score(best_score),
      .best_rate(best_rate), .done(done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_cnt++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [15:0] lam);
      start = 1'b1; lambda = lam; step(); start = 1'b0;
   endtask

   task automatic send(input logic [31:0] r, input logic [31:0] d, input logic [31:0] s);
      in_valid = 1'b1; rate = r; disto = d; sd = s; step();
   endtask

   task automatic test1_seq();
      do_start(16'd10);
      send(100, 50, 0); send(200, 20, 0); send(50, 30, 0); send(300, 10, 0);
      in_valid = 1'b0;
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_mode", 64'(best_mode), 64'd0);
      chk("rst_score", best_score, 64'd0);
      chk("rst_rate", 64'(best_rate), 64'd0);
      rst_n = 1'b1;
      step();

      // test 1: basic decision, done timing
      d0 = done_cnt;
      test1_seq();
      chk("t1_done_early", 64'(done), 64'd0);
      chk("t1_busy_mid", 64'(busy), 64'd1);
      step();
      chk("t1_done", 64'(done), 64'd1);
      chk("t1_busy_fall", 64'(busy), 64'd0);
      chk("t1_mode", 64'(best_mode), 64'd3);
      chk("t1_score", best_score, 64'd5560);
      chk("t1_rate", 64'(best_rate), 64'd300);
      step();
      chk("t1_done_pulse", 64'(done), 64'd0);
      chk("t1_hold_score", best_score, 64'd5560);
      chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);

      // test 2: ties keep the lowest index
      do_start(16'd1);
      chk("t2_hold_after_start", best_score, 64'd5560);
      for (int i = 0; i < 4; i++) send(10, 1, 1);
      in_valid = 1'b0;
      step();
      chk("t2_done", 64'(done), 64'd1);
      chk("t2_mode", 64'(best_mode), 64'd0);
      chk("t2_score", best_score, 64'd522);
      chk("t2_rate", 64'(best_rate), 64'd10);
      step();

      // test 3: extremes
      do_start(16'hFFFF);
      for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      in_valid = 1'b0;
      step();
      chk("t3_done", 64'(done), 64'd1);
      chk("t3_mode", 64'(best_mode), 64'd0);
      chk("t3_score", best_score, 64'hFFFF_FFFF * 64'hFFFF + 64'h1_FFFF_FFFE * 64'd256);
      chk("t3_rate", 64'(best_rate), 64'hFFFF_FFFF);
      step();

      // test 4: abort mid-decision
      d0 = done_cnt;
      do_start(16'd7);
      send(1, 0, 0); send(1, 0, 0);
      in_valid = 1'b0;
      do_start(16'd1);
      send(5, 0, 0); send(4, 0, 0); send(3, 0, 0); send(6, 0, 0);
      in_valid = 1'b0;
      step();
      chk("t4_done", 64'(done), 64'd1);
      chk("t4_mode", 64'(best_mode), 64'd2);
      chk("t4_score", best_score, 64'd3);
      step(); step();
      chk("t4_done_cnt", 64'(done_cnt - d0), 64'd1);

      // test 5: spurious in_valids
      d0 = done_cnt;
      send(1, 0, 0);            // while idle
      in_valid = 1'b0;
      step();
      chk("t5_idle_busy", 64'(busy), 64'd0);
      chk("t5_idle_score", best_score, 64'd3);
      start = 1'b1; lambda = 16'd10;
      in_valid = 1'b1; rate = 1; disto = 0; sd = 0;   // dropped with start
      step();
      start = 1'b0;
      send(100, 50, 0); send(200, 20, 0); send(50, 30, 0); send(300, 10, 0);
      send(1, 0, 0);            // fifth entry, ignored
      in_valid = 1'b0;
      chk("t5_done", 64'(done), 64'd1);
      chk("t5_mode", 64'(best_mode), 64'd3);
      chk("t5_score", best_score, 64'd5560);
      chk("t5_rate", 64'(best_rate), 64'd300);
      step(); step(); step();
      chk("t5_done_cnt", 64'(done_cnt - d0), 64'd1);

      // test 6: reset between third and fourth in_valid
      d0 = done_cnt;
      do_start(16'd10);
      send(100, 50, 0); send(200, 20, 0); send(50, 30, 0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_done", 64'(done), 64'd0);
      chk("t6_mode", 64'(best_mode), 64'd0);
      chk("t6_score", best_score, 64'd0);
      chk("t6_rate", 64'(best_rate), 64'd0);
      #3 rst_n = 1'b1;
      send(300, 10, 0);         // no decision open: ignored
      in_valid = 1'b0;
      step(); step(); step();
      chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
      chk("t6_idle_busy", 64'(busy), 64'd0);
      test1_seq();
      step();
      chk("t6_redo_done", 64'(done), 64'd1);
      chk("t6_redo_mode", 64'(best_mode), 64'd3);
      chk("t6_redo_score", best_score, 64'd5560);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
